// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: FSM state encoding and default operand width.
package arith_pkg;

   localparam int unsigned ARITH_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin, bout set when the bit borrows.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock with a registered borrow.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = ARITH_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sd_q, sd_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d, zero_q, zero_d;
   logic             fs_d, fs_bout;

   full_subtractor u_fs (
      .x   (sa_q[0]),
      .y   (sb_q[0]),
      .bin (br_q),
      .d   (fs_d),
      .bout(fs_bout)
   );

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      sd_d     = sd_q;
      br_d     = br_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      zero_d   = zero_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               sa_d    = a;
               sb_d    = b;
               br_d    = 1'b0;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            sd_d  = {fs_d, sd_q[WIDTH-1:1]};
            br_d  = fs_bout;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d  = S_DONE;
               diff_d   = sd_d;
               borrow_d = fs_bout;
               zero_d   = (sd_d == '0);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         sd_q     <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         sd_q     <= sd_d;
         br_q     <= br_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         zero_q   <= zero_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;
   assign zero   = zero_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: cycle-level behavioural model plus directed and random stimulus.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         busy, done, borrow, zero;
   logic [W-1:0] diff;

   int checks = 0;
   int passes = 0;
   bit cmp_en = 1'b0;
   int done_seen = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .borrow(borrow),
      .zero  (zero)
   );

   always #5 clk = ~clk;

   // Model: ph counts cycles since capture (0 idle, 1..W busy, W+1 done cycle)
   int           ph;
   int           pa, pb;
   logic [W-1:0] m_diff;
   logic         m_borrow, m_zero;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph <= 0; m_diff <= '0; m_borrow <= 1'b0; m_zero <= 1'b1;
      end else if (ph == 0) begin
         if (start) begin
            ph <= 1; pa <= int'(a); pb <= int'(b);
         end
      end else if (ph < W) begin
         ph <= ph + 1;
      end else if (ph == W) begin
         ph       <= W + 1;
         m_diff   <= W'((pa - pb + (1 << W)) % (1 << W));
         m_borrow <= (pa < pb);
         m_zero   <= (pa == pb);
      end else begin
         ph <= 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("outputs{busy,done,diff,borrow,zero}",
             32'({busy, done, diff, borrow, zero}),
             32'({(ph >= 1 && ph <= W), (ph == W + 1), m_diff, m_borrow, m_zero}));
         if (done) done_seen++;
      end
   end

   task automatic wait_done(output int n);
      n = 0;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk); #1;
         if (done) begin
            n = i;
            return;
         end
      end
      chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ed, input logic eb, input logic ez);
      int n;
      @(negedge clk);
      a = ia; b = ib; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = W'($urandom); b = W'($urandom);
      wait_done(n);
      chk("latency", 32'(n), 32'(W));
      chk("diff", 32'(diff), 32'(ed));
      chk("borrow", 32'(borrow), 32'(eb));
      chk("zero", 32'(zero), 32'(ez));
      chk("model_diff", 32'(m_diff), 32'(ed));
      @(posedge clk); #1;
      chk("done_width", 32'(done), 32'd0);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int n;
      int dn;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_borrow", 32'(borrow), 32'd0);
      chk("rst_zero", 32'(zero), 32'd1);
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
      run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
      run_op(8'h80, 8'h80, 8'h00, 1'b0, 1'b1);
      run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);

      // Held start, minuend changed while the first operation runs
      @(negedge clk);
      a = 8'h10; b = 8'h01; start = 1'b1;
      @(posedge clk); #1;
      a = 8'h33;
      wait_done(n);
      chk("held_latency", 32'(n), 32'd8);
      chk("held_first", 32'(diff), 32'h0F);
      wait_done(n);
      chk("held_period1", 32'(n), 32'd10);
      chk("held_second", 32'(diff), 32'h32);
      wait_done(n);
      chk("held_period2", 32'(n), 32'd10);
      start = 1'b0;
      repeat (4) @(posedge clk);

      // Reset in the middle of RUN
      @(negedge clk);
      a = 8'hF0; b = 8'h0F; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_diff", 32'(diff), 32'd0);
      chk("midrst_borrow", 32'(borrow), 32'd0);
      chk("midrst_zero", 32'(zero), 32'd1);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      dn = done_seen;
      repeat (12) @(posedge clk);
      chk("no_done_after_rst", 32'(done_seen - dn), 32'd0);
      run_op(8'h20, 8'h01, 8'h1F, 1'b0, 1'b0);

      // Random traffic, including start pulses during RUN/DONE and operand churn
      dn = done_seen;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         a = W'($urandom);
         b = W'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(posedge clk);
      chk("random_ops_completed", 32'(done_seen - dn > 20), 32'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule : tb_serial_subtractor
